// File: rtl/mem_bus_sequencer.sv
// Round-robin multi-channel sequencer for a multiplexed address/data memory bus.
// Each transfer runs ADDR -> ACCESS (fixed wait states plus nWait stretching, with timeout) -> DONE.
module mem_bus_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int N_CH        = 2,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [N_CH-1:0]          ReqValid,
  input  logic [N_CH-1:0]          ReqRnW,
  input  logic [N_CH*ADDR_W-1:0]   ReqAddr,
  input  logic [N_CH*DATA_W-1:0]   ReqWData,
  output logic [N_CH-1:0]          ReqReady,
  output logic [N_CH-1:0]          RspValid,
  output logic [DATA_W-1:0]        RspData,
  output logic                     RspErr,
  output logic                     Busy,
  output logic [DATA_W-1:0]        BusOut,
  input  logic [DATA_W-1:0]        BusIn,
  output logic                     ALE,
  output logic                     nME,
  output logic                     nOE,
  output logic                     RnW,
  output logic                     ENB,
  input  logic                     nWait
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT_STATES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

  state_t            state, stateNext;
  logic [PW-1:0]     rrPtr;
  logic [PW-1:0]     grantIdx;
  logic              grantAny;
  logic [PW-1:0]     chReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wDataReg;
  logic [DATA_W-1:0] rDataReg;
  logic              rnwReg;
  logic              errReg;
  logic [3:0]        waitCnt;
  logic [TW-1:0]     toCnt;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    grantAny = 1'b0;
    grantIdx = '0;
    idx      = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = PW'((int'(rrPtr) + k) % N_CH);
      if (!grantAny && ReqValid[idx]) begin
        grantAny = 1'b1;
        grantIdx = idx;
      end
    end
  end

  always_comb begin
    stateNext = state;
    ReqReady  = '0;
    RspValid  = '0;
    RspData   = '0;
    RspErr    = 1'b0;
    BusOut    = '0;
    ALE       = 1'b0;
    nME       = 1'b1;
    nOE       = 1'b1;
    RnW       = 1'b1;
    ENB       = 1'b0;
    case (state)
      IDLE: begin
        if (grantAny) begin
          ReqReady[grantIdx] = 1'b1;
          stateNext          = ADDR;
        end
      end
      ADDR: begin
        ALE       = 1'b1;
        ENB       = 1'b1;
        BusOut    = DATA_W'(addrReg);
        RnW       = rnwReg;
        stateNext = ACCESS;
      end
      ACCESS: begin
        nME = 1'b0;
        RnW = rnwReg;
        if (rnwReg) begin
          nOE = 1'b0;
        end else begin
          ENB    = 1'b1;
          BusOut = wDataReg;
        end
        // Only the final access cycle honours nWait; each low sample stretches by one.
        if (waitCnt == WAIT_LAST) begin
          if (nWait || (toCnt == TO_LAST)) stateNext = DONE;
        end
      end
      DONE: begin
        RspValid[chReg] = 1'b1;
        RspData         = rDataReg;
        RspErr          = errReg;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      rrPtr    <= '0;
      chReg    <= '0;
      addrReg  <= '0;
      wDataReg <= '0;
      rDataReg <= '0;
      rnwReg   <= 1'b1;
      errReg   <= 1'b0;
      waitCnt  <= '0;
      toCnt    <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (grantAny) begin
            chReg    <= grantIdx;
            rnwReg   <= ReqRnW[grantIdx];
            addrReg  <= ReqAddr[int'(grantIdx)*ADDR_W +: ADDR_W];
            wDataReg <= ReqWData[int'(grantIdx)*DATA_W +: DATA_W];
            rDataReg <= '0;
            errReg   <= 1'b0;
            rrPtr    <= PW'((int'(grantIdx) + 1) % N_CH);
          end
        end
        ADDR: begin
          waitCnt <= '0;
          toCnt   <= '0;
        end
        ACCESS: begin
          if (waitCnt != WAIT_LAST) begin
            waitCnt <= waitCnt + 4'd1;
          end else if (nWait) begin
            if (rnwReg) rDataReg <= BusIn;
          end else if (toCnt == TO_LAST) begin
            errReg   <= 1'b1;
            rDataReg <= '0;
          end else begin
            toCnt <= toCnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Scoreboard bench for mem_bus_sequencer: directed scenarios plus randomized traffic
// against a round-robin/memory reference model and an emulated external memory device.
module tb_mem_bus_sequencer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int N_CH   = 2;
  localparam int WS     = 1;
  localparam int TO     = 15;

  logic                   Clock = 1'b0;
  logic                   Reset;
  logic [N_CH-1:0]        ReqValid, ReqRnW;
  logic [N_CH*ADDR_W-1:0] ReqAddr;
  logic [N_CH*DATA_W-1:0] ReqWData;
  logic [N_CH-1:0]        ReqReady, RspValid;
  logic [DATA_W-1:0]      RspData, BusOut, BusIn;
  logic                   RspErr, Busy, ALE, nME, nOE, RnW, ENB;
  logic                   nWaitDrv;

  logic [ADDR_W-1:0] tAddr  [N_CH];
  logic [DATA_W-1:0] tWData [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_pack
    assign ReqAddr[i*ADDR_W +: ADDR_W]  = tAddr[i];
    assign ReqWData[i*DATA_W +: DATA_W] = tWData[i];
  end

  always #5 Clock = ~Clock;

  mem_bus_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .WAIT_STATES(WS), .TIMEOUT(TO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqRnW(ReqRnW),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqReady(ReqReady), .RspValid(RspValid),
    .RspData(RspData), .RspErr(RspErr), .Busy(Busy), .BusOut(BusOut), .BusIn(BusIn),
    .ALE(ALE), .nME(nME), .nOE(nOE), .RnW(RnW), .ENB(ENB), .nWait(nWaitDrv)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // External memory: drives its data only while output-enabled and not requesting wait.
  function automatic logic [15:0] devRead(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a * 16'd3 + 16'h5A5A);
  endfunction

  logic [ADDR_W-1:0] devAddr = '0;
  assign BusIn = (!nOE && nWaitDrv) ? devRead(devAddr) : 16'h0BAD;

  function automatic int modelGrant(input logic [N_CH-1:0] v, input int p);
    for (int k = 0; k < N_CH; k++) begin
      if (v[(p + k) % N_CH]) return (p + k) % N_CH;
    end
    return -1;
  endfunction

  typedef struct {
    int          ch;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t        expQ[$];
  int          grantLog[$];
  int          grantCnt [N_CH];
  int          rspCnt = 0;
  int          ptr = 0;
  logic        expectTimeout;
  logic        curRnW = 1'b1;
  logic [15:0] curAddr = '0;
  logic [15:0] curWData = '0;

  initial for (int i = 0; i < N_CH; i++) grantCnt[i] = 0;

  // Monitor: scoreboard pops on responses, grant model checked whenever idle.
  always @(negedge Clock) begin
    int   g;
    rsp_t e;
    if (RspValid != '0) begin
      rspCnt++;
      if (expQ.size() == 0) begin
        chk("rspUnexpected", 32'(RspValid), 32'd0);
      end else begin
        e = expQ.pop_front();
        chk("rspCh", 32'(RspValid), 32'(1 << e.ch));
        chk("rspData", 32'(RspData), 32'(e.data));
        chk("rspErr", 32'(RspErr), 32'(e.err));
      end
    end
    if (!Reset) begin
      g = Busy ? -1 : modelGrant(ReqValid, ptr);
      chk("grant", 32'(ReqReady), (g >= 0) ? 32'(1 << g) : 32'd0);
      if (g >= 0) begin
        e.ch   = g;
        e.err  = expectTimeout;
        e.data = (ReqRnW[g] && !expectTimeout) ? devRead(tAddr[g]) : 16'h0;
        expQ.push_back(e);
        curRnW   = ReqRnW[g];
        curAddr  = tAddr[g];
        curWData = tWData[g];
        ptr      = (g + 1) % N_CH;
        grantCnt[g]++;
        grantLog.push_back(g);
      end
      if (ALE) begin
        chk("aleAddr", 32'(BusOut), 32'(curAddr));
        devAddr = BusOut;
      end
      if (!nME) begin
        if (curRnW) chk("readDrive", {ENB, nOE, RnW, BusOut}, {1'b0, 1'b0, 1'b1, 16'h0});
        else        chk("writeDrive", {ENB, nOE, RnW, BusOut}, {1'b1, 1'b1, 1'b0, curWData});
      end
    end else begin
      expQ.delete();
      ptr = 0;
    end
  end

  task automatic doReset();
    Reset         = 1'b1;
    ReqValid      = '0;
    nWaitDrv      = 1'b1;
    expectTimeout = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  task automatic setReq(input int ch, input logic rnw, input logic [15:0] a, input logic [15:0] d);
    ReqRnW[ch]   = rnw;
    tAddr[ch]    = a;
    tWData[ch]   = d;
    ReqValid[ch] = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    ReqValid = '0;
    nWaitDrv = 1'b1;
    n = 0;
    while ((Busy || expQ.size() != 0) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    chk(name, 32'(expQ.size()), 32'd0);
    @(posedge Clock); #1;
  endtask

  initial begin
    int seen [N_CH];
    int lowStreak;
    int n;
    Reset = 1'b1;
    ReqValid = '0;
    ReqRnW = '0;
    nWaitDrv = 1'b1;
    expectTimeout = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      tAddr[i]  = '0;
      tWData[i] = '0;
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    @(negedge Clock);
    chk("rstReqReady", 32'(ReqReady), 32'd0);
    chk("rstRspValid", 32'(RspValid), 32'd0);
    chk("rstRspData", 32'(RspData), 32'd0);
    chk("rstRspErr", 32'(RspErr), 32'd0);
    chk("rstBusy", 32'(Busy), 32'd0);
    chk("rstBusOut", 32'(BusOut), 32'd0);
    chk("rstStrobes", {ALE, nME, nOE, RnW, ENB}, 5'b01110);

    // Channel 0 read of 0x1234, cycle-by-cycle.
    @(posedge Clock); #1 setReq(0, 1'b1, 16'h1234, 16'h0);
    @(negedge Clock); chk("t19Ready", 32'(ReqReady), 32'b01);
    @(posedge Clock); #1 ReqValid = '0;
    @(negedge Clock);
    chk("t19Addr", {ALE, ENB, nME, nOE, BusOut}, {1'b1, 1'b1, 1'b1, 1'b1, 16'h1234});
    chk("t19Busy", 32'(Busy), 32'd1);
    repeat (2) begin
      @(negedge Clock); chk("t19Access", {nME, nOE, RspValid}, 4'b0000);
    end
    @(negedge Clock);
    chk("t19Rsp", {RspValid, RspErr, RspData}, {2'b01, 1'b0, 16'hBEEF});
    @(negedge Clock); chk("t19Idle", 32'(Busy), 32'd0);

    // Channel 1 write of 0x00A5 to 0x0040.
    @(posedge Clock); #1 setReq(1, 1'b0, 16'h0040, 16'h00A5);
    @(negedge Clock); chk("t20Ready", 32'(ReqReady), 32'b10);
    @(posedge Clock); #1 ReqValid = '0;
    @(negedge Clock); chk("t20Addr", {ENB, ALE, RnW, BusOut}, {1'b1, 1'b1, 1'b0, 16'h0040});
    repeat (2) begin
      @(negedge Clock);
      chk("t20Access", {ENB, RnW, nME, nOE, BusOut}, {1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5});
    end
    @(negedge Clock); chk("t20Rsp", {RspValid, RspData}, {2'b10, 16'h0000});

    // Both channels requesting continuously from reset alternate.
    doReset();
    grantLog.delete();
    for (int i = 0; i < N_CH; i++) begin
      seen[i] = grantCnt[i];
      setReq(i, 1'($urandom), 16'($urandom), 16'($urandom));
    end
    repeat (30) begin
      @(posedge Clock); #1;
      for (int i = 0; i < N_CH; i++) begin
        if (grantCnt[i] != seen[i]) begin
          seen[i] = grantCnt[i];
          setReq(i, 1'($urandom), 16'($urandom), 16'($urandom));
        end
      end
    end
    chk("t21Count", 32'(grantLog.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) chk("t21Order", 32'(grantLog[i]), 32'(i % 2));
    drain("t21Drain");

    // nWait low for three samples starting at the last access cycle.
    doReset();
    setReq(0, 1'b1, 16'h0100, 16'h0);
    @(negedge Clock); chk("t22Ready", 32'(ReqReady), 32'b01);
    @(posedge Clock); #1 ReqValid = '0;
    repeat (2) @(posedge Clock);
    #1 nWaitDrv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); chk("t22Ext", 32'(nME), 32'd0);
      @(posedge Clock);
    end
    #1 nWaitDrv = 1'b1;
    @(negedge Clock); chk("t22Hold", {nME, RspValid}, 3'b000);
    @(negedge Clock); chk("t22Rsp", {RspValid, RspErr, RspData}, {2'b01, 1'b0, devRead(16'h0100)});

    // nWait stuck low: abort after TO extension cycles, then normal traffic.
    doReset();
    expectTimeout = 1'b1;
    nWaitDrv = 1'b0;
    setReq(0, 1'b1, 16'h0200, 16'h0);
    @(negedge Clock); chk("t23Ready", 32'(ReqReady), 32'b01);
    @(posedge Clock); #1 ReqValid = '0; expectTimeout = 1'b0;
    for (int k = 1; k <= 3 + TO; k++) begin
      @(negedge Clock); chk("t23Early", 32'(RspValid), 32'd0);
    end
    @(negedge Clock); chk("t23Rsp", {RspValid, RspErr, RspData}, {2'b01, 1'b1, 16'h0000});
    @(posedge Clock); #1 nWaitDrv = 1'b1;
    setReq(1, 1'b1, 16'h0321, 16'h0);
    n = rspCnt;
    for (int k = 0; k < 40 && rspCnt == n; k++) begin
      @(posedge Clock); #1;
      if (grantCnt[1] != 0) ReqValid[1] = 1'b0;
    end
    chk("t23After", 32'(rspCnt - n), 32'd1);

    // Reset in the middle of an access.
    doReset();
    setReq(0, 1'b1, 16'h0300, 16'h0);
    @(negedge Clock); chk("t24Ready", 32'(ReqReady), 32'b01);
    @(posedge Clock); #1 ReqValid = '0;
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock); #1 Reset = 1'b0;
    setReq(0, 1'b0, 16'h0011, 16'h2222);
    setReq(1, 1'b1, 16'h0033, 16'h0);
    @(negedge Clock);
    chk("t24Strobes", {nME, nOE, ENB, Busy, RspValid}, {1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
    chk("t24Grant", 32'(ReqReady), 32'b01);
    @(posedge Clock); #1 ReqValid[0] = 1'b0;
    n = grantCnt[1];
    for (int k = 0; k < 40 && grantCnt[1] == n; k++) @(negedge Clock);
    chk("t24Second", 32'(grantCnt[1] - n), 32'd1);
    drain("t24Drain");

    // Randomized traffic with random drops and bounded wait stretching.
    doReset();
    lowStreak = 0;
    for (int i = 0; i < N_CH; i++) seen[i] = grantCnt[i];
    repeat (3000) begin
      @(posedge Clock); #1;
      for (int i = 0; i < N_CH; i++) begin
        if (grantCnt[i] != seen[i]) begin
          seen[i] = grantCnt[i];
          ReqValid[i] = 1'b0;
          if ($urandom_range(1, 0) == 1) setReq(i, 1'($urandom), 16'($urandom), 16'($urandom));
        end else if (!ReqValid[i]) begin
          if ($urandom_range(2, 0) == 0) setReq(i, 1'($urandom), 16'($urandom), 16'($urandom));
        end else if ($urandom_range(19, 0) == 0) begin
          ReqValid[i] = 1'b0;
        end
      end
      if (lowStreak < 4 && $urandom_range(3, 0) == 0) begin
        nWaitDrv = 1'b0;
        lowStreak++;
      end else begin
        nWaitDrv = 1'b1;
        lowStreak = 0;
      end
    end
    drain("randDrain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
